// File: rtl/seg_scan_decoder_if.sv
// Bus bundle for seg_scan_decoder: snooped display pins plus the frame valid/ready port.
// The slave modport is the decoder's view; the master modport is the display/consumer side.
interface seg_scan_decoder_if #(
    parameter int unsigned DIGITS = 4
);
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                frame_ready;
    logic [4*DIGITS-1:0] digit_q;
    logic [DIGITS-1:0]   digit_err;
    logic                frame_valid;
    logic                overrun;

    modport master (
        output an, seg, frame_ready,
        input  digit_q, digit_err, frame_valid, overrun
    );

    modport slave (
        input  an, seg, frame_ready,
        output digit_q, digit_err, frame_valid, overrun
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: snoops a multiplexed active-low 7-segment bus, waits for each scanned digit
// to hold steady, decodes it back to a hex nibble and delivers one frame per full scan on a
// valid/ready port.
// Optional build macro SEG_ERR_COUNT_EN adds an 8-bit saturating count of illegal-pattern captures.
module seg_scan_decoder #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_decoder_if.slave bus
`ifdef SEG_ERR_COUNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHeld
    } state_e;

    // The sample that exposes a change is the first of its window, so a window of
    // STABLE_CYCLES identical samples is reached when the repeat count hits STABLE_CYCLES-1.
    localparam logic [7:0] StableMax  = 8'(STABLE_CYCLES);
    localparam logic [7:0] StableLast = 8'(STABLE_CYCLES - 1);

    // Returns {err, nibble}; unmatched patterns decode to nibble 0 with err set.
    function automatic logic [4:0] decode_seg(input logic [6:0] pattern);
        logic [4:0] res;
        case (pattern)
            7'h40:   res = 5'h00;
            7'h79:   res = 5'h01;
            7'h24:   res = 5'h02;
            7'h30:   res = 5'h03;
            7'h19:   res = 5'h04;
            7'h12:   res = 5'h05;
            7'h02:   res = 5'h06;
            7'h78:   res = 5'h07;
            7'h00:   res = 5'h08;
            7'h18:   res = 5'h09;
            7'h08:   res = 5'h0A;
            7'h03:   res = 5'h0B;
            7'h27:   res = 5'h0C;
            7'h21:   res = 5'h0D;
            7'h06:   res = 5'h0E;
            7'h0E:   res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

    logic [DIGITS-1:0]   an_m;
    logic [DIGITS-1:0]   an_s;
    logic [DIGITS-1:0]   an_p;
    logic [6:0]          seg_m;
    logic [6:0]          seg_s;
    logic [6:0]          seg_p;
    logic [7:0]          stable_cnt;
    state_e              state;
    logic [DIGITS-1:0]   seen;
    logic [4*DIGITS-1:0] shadow_digit;
    logic [DIGITS-1:0]   shadow_err;
    logic [4*DIGITS-1:0] frame_digit;
    logic [DIGITS-1:0]   frame_err;
    logic                frame_valid_r;
    logic                overrun_r;

    logic                sample_change;
    logic                anode_legal;
    logic [7:0]          stable_cnt_next;
    logic                capture;
    logic [DIGITS-1:0]   capture_mask;
    logic                frame_full;
    logic                frame_load;
    logic                xfer;
    logic [3:0]          dec_nibble;
    logic                dec_err;

    assign {dec_err, dec_nibble} = decode_seg(seg_s);

    // Change detection, stability count, capture and frame-completion decisions.
    always_comb begin
        sample_change = {an_s, seg_s} != {an_p, seg_p};
        anode_legal   = $onehot(~an_s);
        if (sample_change) begin
            stable_cnt_next = 8'd0;
        end else if (stable_cnt == StableMax) begin
            stable_cnt_next = stable_cnt;
        end else begin
            stable_cnt_next = stable_cnt + 8'd1;
        end
        capture      = (state == StSettle) && !sample_change && (stable_cnt_next == StableLast);
        capture_mask = capture ? ~an_s : '0;
        frame_full   = &seen;
        frame_load   = frame_full && (!frame_valid_r || bus.frame_ready);
        xfer         = frame_valid_r && bus.frame_ready;
    end

    // Two-flop synchronizers on the pins plus the previous-sample register for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_m  <= '0;
            an_s  <= '0;
            an_p  <= '0;
            seg_m <= '0;
            seg_s <= '0;
            seg_p <= '0;
        end else begin
            an_m  <= bus.an;
            an_s  <= an_m;
            an_p  <= an_s;
            seg_m <= bus.seg;
            seg_s <= seg_m;
            seg_p <= seg_s;
        end
    end

    // Saturating count of repeats of the current sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt_next;
        end
    end

    // Scan FSM: wait for a legal anode, let it settle, capture once per stable window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
        end else begin
            unique case (state)
                StIdle: begin
                    if (sample_change && anode_legal) begin
                        state <= StSettle;
                    end
                end
                StSettle: begin
                    if (sample_change) begin
                        state <= anode_legal ? StSettle : StIdle;
                    end else if (capture) begin
                        state <= StHeld;
                    end
                end
                StHeld: begin
                    if (sample_change) begin
                        state <= anode_legal ? StSettle : StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Shadow slots and seen mask; a completed frame clears seen on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen         <= '0;
            shadow_digit <= '0;
            shadow_err   <= '0;
        end else begin
            seen <= (frame_full ? '0 : seen) | capture_mask;
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (capture_mask[i]) begin
                    shadow_digit[4*i +: 4] <= dec_nibble;
                    shadow_err[i]          <= dec_err;
                end
            end
        end
    end

    // Output frame register and handshake; a load on the transfer edge keeps frame_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_digit   <= '0;
            frame_err     <= '0;
            frame_valid_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else if (frame_load) begin
            frame_digit   <= shadow_digit;
            frame_err     <= shadow_err;
            frame_valid_r <= 1'b1;
            overrun_r     <= 1'b0;
        end else if (frame_full) begin
            overrun_r <= 1'b1;
        end else if (xfer) begin
            frame_valid_r <= 1'b0;
            overrun_r     <= 1'b0;
        end
    end

    assign bus.digit_q     = frame_digit;
    assign bus.digit_err   = frame_err;
    assign bus.frame_valid = frame_valid_r;
    assign bus.overrun     = overrun_r;

`ifdef SEG_ERR_COUNT_EN
    logic [7:0] err_cnt_r;

    // Saturating tally of captures whose pattern was not in the code table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= '0;
        end else if (capture && dec_err && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end

    assign err_count = err_cnt_r;
`endif

endmodule
